// File: rtl/stdp_pkg.sv
// Shared constants and fixed-point helpers for the STDP synapse array:
// default parameters, the ONE derivation, width helpers and the weight clamp.
package stdp_pkg;

  localparam int DEF_N_PRE         = 4;
  localparam int DEF_WIDTH         = 16;
  localparam int DEF_DECIMAL_BITS  = 7;
  localparam int DEF_TRACE_SHIFT   = 4;
  localparam int DEF_A_PLUS_SHIFT  = 5;
  localparam int DEF_A_MINUS_SHIFT = 6;
  localparam int DEF_I_SHIFT       = 2;
  localparam int DEF_MODE          = 0;

  typedef logic signed [63:0] fx_wide_t;
  typedef logic        [63:0] fx_uwide_t;

  function automatic int one_of(input int decimal_bits);
    return 32'sd1 << decimal_bits;
  endfunction

  localparam int DEF_ONE    = one_of(DEF_DECIMAL_BITS);
  localparam int DEF_W_MAX  = DEF_ONE;
  localparam int DEF_W_INIT = DEF_ONE / 2;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Accumulator width able to hold the sum of n values of 'width' bits.
  function automatic int sum_width(input int width, input int n);
    return width + $clog2(n + 1);
  endfunction

  function automatic fx_uwide_t clamp_u(input fx_wide_t v, input fx_uwide_t hi);
    fx_uwide_t r;
    if (v < 64'sd0) begin
      r = 64'd0;
    end else if (fx_uwide_t'(v) > hi) begin
      r = hi;
    end else begin
      r = fx_uwide_t'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/stdp_trace.sv
// One exponentially decaying spike trace: subtract t>>TRACE_SHIFT each cycle,
// add ONE on a spike, saturate at the all-ones value.
module stdp_trace
  import stdp_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DECIMAL_BITS = DEF_DECIMAL_BITS,
  parameter int TRACE_SHIFT  = DEF_TRACE_SHIFT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spike_i,
  output logic [WIDTH-1:0] trace_o
);

  localparam logic [WIDTH:0] ONE_L = (WIDTH+1)'(one_of(DECIMAL_BITS));

  logic [WIDTH-1:0] trace_q;
  logic [WIDTH-1:0] trace_d;
  logic [WIDTH-1:0] decay_s;
  logic [WIDTH:0]   bump_s;

  // Decay then optional bump with saturation.
  always_comb begin
    decay_s = trace_q - (trace_q >> TRACE_SHIFT);
    bump_s  = {1'b0, decay_s} + ONE_L;
    if (spike_i) begin
      trace_d = bump_s[WIDTH] ? {WIDTH{1'b1}} : bump_s[WIDTH-1:0];
    end else begin
      trace_d = decay_s;
    end
  end

  // Trace register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trace_q <= '0;
    end else begin
      trace_q <= trace_d;
    end
  end

  assign trace_o = trace_q;

endmodule

// File: rtl/stdp_synapse_array.sv
// Array of N_PRE plastic synapses onto one postsynaptic neuron: pair-based STDP
// weight learning, a weight load/readback port and a registered synaptic current.
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int N_PRE         = DEF_N_PRE,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DECIMAL_BITS  = DEF_DECIMAL_BITS,
  parameter int TRACE_SHIFT   = DEF_TRACE_SHIFT,
  parameter int A_PLUS_SHIFT  = DEF_A_PLUS_SHIFT,
  parameter int A_MINUS_SHIFT = DEF_A_MINUS_SHIFT,
  parameter int W_MAX         = one_of(DECIMAL_BITS),
  parameter int W_INIT        = one_of(DECIMAL_BITS) / 2,
  parameter int I_SHIFT       = DEF_I_SHIFT,
  parameter int MODE          = DEF_MODE,
  localparam int AW           = addr_width(N_PRE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_PRE-1:0] pre_spike,
  input  logic             post_spike,
  input  logic             learn_en,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] i_syn
);

  localparam int             SUMW     = sum_width(WIDTH, N_PRE);
  localparam logic [WIDTH-1:0] W_MAX_L  = WIDTH'(W_MAX);
  localparam logic [WIDTH-1:0] W_INIT_L = WIDTH'(W_INIT);

  logic [WIDTH-1:0] pre_trace_s [N_PRE];
  logic [WIDTH-1:0] post_trace_s;
  logic [WIDTH-1:0] dwp_s [N_PRE];
  logic [WIDTH-1:0] dwm_s [N_PRE];
  logic [WIDTH-1:0] w_q [N_PRE];
  logic [WIDTH-1:0] w_d [N_PRE];
  logic [WIDTH-1:0] i_syn_q, i_syn_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  for (genvar g = 0; g < N_PRE; g++) begin : g_pre_trace
    stdp_trace #(.WIDTH(WIDTH), .DECIMAL_BITS(DECIMAL_BITS), .TRACE_SHIFT(TRACE_SHIFT)) u_trace (
      .clk(clk), .reset_n(reset_n), .spike_i(pre_spike[g]), .trace_o(pre_trace_s[g])
    );
  end

  stdp_trace #(.WIDTH(WIDTH), .DECIMAL_BITS(DECIMAL_BITS), .TRACE_SHIFT(TRACE_SHIFT)) u_post_trace (
    .clk(clk), .reset_n(reset_n), .spike_i(post_spike), .trace_o(post_trace_s)
  );

  // Soft-bound terms scale with the distance to each bound; additive terms do not.
  if (MODE == 0) begin : g_mult
    for (genvar g = 0; g < N_PRE; g++) begin : g_ch
      logic [2*WIDTH-1:0] ltp_prod_s;
      logic [2*WIDTH-1:0] ltd_prod_s;
      assign ltp_prod_s = (2*WIDTH)'(pre_trace_s[g]) * (2*WIDTH)'(W_MAX_L - w_q[g]);
      assign ltd_prod_s = (2*WIDTH)'(post_trace_s) * (2*WIDTH)'(w_q[g]);
      assign dwp_s[g]   = WIDTH'(ltp_prod_s >> (DECIMAL_BITS + A_PLUS_SHIFT));
      assign dwm_s[g]   = WIDTH'(ltd_prod_s >> (DECIMAL_BITS + A_MINUS_SHIFT));
    end
  end else begin : g_add
    for (genvar g = 0; g < N_PRE; g++) begin : g_ch
      assign dwp_s[g] = pre_trace_s[g] >> A_PLUS_SHIFT;
      assign dwm_s[g] = post_trace_s >> A_MINUS_SHIFT;
    end
  end

  // Next weights (learning, then load override), readback and current.
  always_comb begin
    logic signed [WIDTH+1:0] upd_v;
    fx_uwide_t               clamped_v;
    logic [SUMW-1:0]         acc_v;
    upd_v     = '0;
    clamped_v = '0;
    acc_v     = '0;
    rd_data_d = '0;
    for (int i = 0; i < N_PRE; i++) begin
      upd_v = $signed({2'b00, w_q[i]})
            + ((learn_en && post_spike)   ? $signed({2'b00, dwp_s[i]}) : $signed({(WIDTH+2){1'b0}}))
            - ((learn_en && pre_spike[i]) ? $signed({2'b00, dwm_s[i]}) : $signed({(WIDTH+2){1'b0}}));
      clamped_v = clamp_u(fx_wide_t'(upd_v), fx_uwide_t'(W_MAX_L));
      w_d[i] = (wr_en && (32'(wr_addr) == i)) ? ((wr_data > W_MAX_L) ? W_MAX_L : wr_data)
                                               : clamped_v[WIDTH-1:0];
      acc_v = acc_v + (pre_spike[i] ? SUMW'(w_q[i] >> I_SHIFT) : {SUMW{1'b0}});
      rd_data_d = (32'(rd_addr) == i) ? w_q[i] : rd_data_d;
    end
    i_syn_d = ((acc_v >> WIDTH) != {SUMW{1'b0}}) ? {WIDTH{1'b1}} : acc_v[WIDTH-1:0];
  end

  // Weight and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PRE; i++) w_q[i] <= W_INIT_L;
      i_syn_q   <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < N_PRE; i++) w_q[i] <= w_d[i];
      i_syn_q   <= i_syn_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign i_syn   = i_syn_q;

endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed and randomized bench for stdp_synapse_array against an arithmetic
// reference model of the weights and traces.
module tb_stdp_synapse_array;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  pre_spike = 4'd0;
  logic        post_spike = 1'b0;
  logic        learn_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [15:0] wr_data = 16'd0;
  logic [1:0]  rd_addr = 2'd0;
  logic [15:0] rd_data;
  logic [15:0] i_syn;

  int checks = 0;
  int failures = 0;

  int m_w [4];
  int m_pre [4];
  int m_post;

  always #5 clk = ~clk;

  stdp_synapse_array dut (
    .clk(clk), .reset_n(reset_n), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .i_syn(i_syn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int trace_next(input int t, input bit s);
    int d;
    d = t - (t >> 4);
    if (s) begin
      d = d + 128;
      if (d > 65535) d = 65535;
    end
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 64;
      m_pre[i] = 0;
    end
    m_post = 0;
  endtask

  // One clock: expected outputs come from the model state before the edge.
  task automatic step(input logic [3:0] pre, input logic post, input logic learn,
                      input logic we, input logic [1:0] wa, input logic [15:0] wd,
                      input logic [1:0] ra, input string tag);
    int exp_rd, exp_is, nw [4];
    longint dwp, dwm;
    exp_rd = m_w[ra];
    exp_is = 0;
    for (int i = 0; i < 4; i++) if (pre[i]) exp_is += m_w[i] / 4;
    if (exp_is > 65535) exp_is = 65535;
    for (int i = 0; i < 4; i++) begin
      dwp = (longint'(m_pre[i]) * longint'(128 - m_w[i])) / 4096;
      dwm = (longint'(m_post) * longint'(m_w[i])) / 8192;
      nw[i] = m_w[i];
      if (learn && post) nw[i] += int'(dwp);
      if (learn && pre[i]) nw[i] -= int'(dwm);
      if (nw[i] < 0) nw[i] = 0;
      if (nw[i] > 128) nw[i] = 128;
      if (we && (int'(wa) == i)) nw[i] = (int'(wd) > 128) ? 128 : int'(wd);
    end
    pre_spike = pre; post_spike = post; learn_en = learn;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    @(posedge clk);
    #1;
    check({tag, "/rd_data"}, 32'(rd_data), 32'(exp_rd));
    check({tag, "/i_syn"}, 32'(i_syn), 32'(exp_is));
    for (int i = 0; i < 4; i++) begin
      m_w[i] = nw[i];
      m_pre[i] = trace_next(m_pre[i], pre[i]);
    end
    m_post = trace_next(m_post, post);
    @(negedge clk);
  endtask

  task automatic idle(input logic [1:0] ra, input string tag);
    step(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, ra, tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "/rst_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "/rst_i_syn"}, 32'(i_syn), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset("init");

    for (int a = 0; a < 4; a++) idle(2'(a), "r030_read");
    idle(2'd3, "r030_last");
    check("r030_w3", 32'(rd_data), 32'd64);

    step(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, "r031_spike");
    check("r031_isyn16", 32'(i_syn), 32'd16);
    idle(2'd0, "r031_after");
    check("r031_isyn0", 32'(i_syn), 32'd0);

    do_reset("r032");
    step(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 2'd0, "r032_pre");
    step(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 2'd0, "r032_post");
    idle(2'd0, "r032_read");
    check("r032_w0", 32'(rd_data), 32'd66);

    do_reset("r033");
    step(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 2'd1, "r033_post");
    step(4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 2'd1, "r033_pre");
    idle(2'd1, "r033_read");
    check("r033_w1", 32'(rd_data), 32'd63);

    do_reset("r034");
    step(4'b0100, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 2'd2, "r034_pre");
    step(4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 16'd200, 2'd2, "r034_wr");
    idle(2'd2, "r034_read");
    check("r034_w2", 32'(rd_data), 32'd128);

    do_reset("r035");
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, "r035_pre");
      step(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 2'd0, "r035_post");
    end
    for (int a = 0; a < 4; a++) begin
      idle(2'(a), "r035_read");
      idle(2'(a), "r035_hold");
      check("r035_w_unchanged", 32'(rd_data), 32'd64);
    end
    for (int k = 0; k < 5; k++) step(4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 16'd0, 2'd0, "r035_train");
    do_reset("r035_mid");
    idle(2'd3, "r035_fresh");
    idle(2'd3, "r035_fresh2");
    check("r035_w3_reset", 32'(rd_data), 32'd64);

    for (int n = 0; n < 600; n++) begin
      logic [3:0] pre;
      for (int i = 0; i < 4; i++) pre[i] = ($urandom_range(0, 3) == 0);
      step(pre, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
           16'($urandom_range(0, 300)), 2'($urandom_range(0, 3)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
